// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the display mux.
// Optional saturation at 9999 with overflow flag: define BIN_BCD_SATURA_EN.
module bin_bcd_seq #(
    parameter int ANCHO = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ANCHO-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             sobre,
    output logic [3:0][3:0]  digitos
);

    // Handshake: start is honoured only in IDLE, bin is captured on that same edge;
    // done pulses for one cycle with digitos new and valid; busy = state != IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } estado_t;

    estado_t          state;
    estado_t          state_next;
    logic [ANCHO-1:0] sr;
    logic [3:0][3:0]  acc;
    logic [3:0][3:0]  acc_adj;
    logic [15:0]      acc_shl;
    logic [3:0]       cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == 4'(ANCHO - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Add-3 correction precedes the shift; anything carried past digit 3 is dropped.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] >= 4'd5) acc_adj[i] = acc[i] + 4'd3;
        end
        acc_shl = (16'(acc_adj) << 1) | {15'd0, sr[ANCHO-1]};
    end

`ifdef BIN_BCD_SATURA_EN
    logic ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            digitos <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc_shl;
                    sr  <= sr << 1;
                    cnt <= cnt + 4'd1;
                end
                FIN: begin
`ifdef BIN_BCD_SATURA_EN
                    digitos <= ovf ? 16'h9999 : acc;
`else
                    digitos <= acc;
`endif
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIN_BCD_SATURA_EN
    // Overflow is judged on the raw input at acceptance and carried to FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf   <= 1'b0;
            sobre <= 1'b0;
        end else begin
            if (state == IDLE && start) ovf <= (14'(bin) > 14'd9999);
            if (state == FIN) sobre <= ovf;
        end
    end
`else
    assign sobre = 1'b0;
`endif

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq (ANCHO=14): latency, boundaries, overflow,
// start-while-busy, held start and asynchronous reset mid-conversion.
module tb_bin_bcd_seq;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [13:0]     bin;
    logic            busy;
    logic            done;
    logic            sobre;
    logic [3:0][3:0] digitos;

    int n_checks = 0;
    int n_fail   = 0;

    bin_bcd_seq #(.ANCHO(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .sobre   (sobre),
        .digitos (digitos)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion from IDLE; checks latency, busy length, hold, result, single pulse.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_dig,
                            input logic exp_sob, input string tag);
        logic [15:0] prev;
        int          got;
        int          busy_n;
        logic        hold_ok;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        prev  = digitos;
        @(posedge clk);
        #1 start = 1'b0;
        got     = -1;
        busy_n  = 0;
        hold_ok = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done) begin
                got = j;
                break;
            end
            if (busy) busy_n++;
            if (digitos !== prev) hold_ok = 1'b0;
        end
        check({tag, "_latency"}, got, 15);
        check({tag, "_busy_cycles"}, busy_n, 15);
        check({tag, "_hold"}, hold_ok, 1);
        check({tag, "_digitos"}, digitos, exp_dig);
        check({tag, "_sobre"}, sobre, exp_sob);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic held_start();
        int          d1;
        int          d2;
        logic [15:0] dig1;
        logic [15:0] dig2;
        logic        b1;
        logic        b2;
        d1 = -1; d2 = -1; dig1 = '0; dig2 = '0; b1 = 1'b1; b2 = 1'b0;
        @(negedge clk);
        bin   = 14'd100;
        start = 1'b1;
        @(posedge clk);
        #1 bin = 14'd200;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = j; dig1 = digitos; b1 = busy;
                end else begin
                    d2 = j; dig2 = digitos;
                    start = 1'b0;
                    break;
                end
            end else if (d1 >= 0 && j == d1 + 1) begin
                b2 = busy;
            end
        end
        start = 1'b0;
        check("held_first_done", d1, 15);
        check("held_first_digitos", dig1, 16'h0100);
        check("held_busy_gap", b1, 0);
        check("held_busy_restart", b2, 1);
        check("held_second_done", d2, 31);
        check("held_second_digitos", dig2, 16'h0200);
        repeat (20) @(negedge clk);
        check("held_idle_after", busy, 0);
    endtask

    task automatic start_while_busy();
        logic [15:0] prev;
        logic [15:0] dig;
        int          n_done;
        int          first;
        logic        hold_ok;
        n_done = 0; first = -1; hold_ok = 1'b1; dig = '0;
        @(negedge clk);
        prev  = digitos;
        bin   = 14'd1234;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (j == 4) begin
                bin   = 14'd4321;
                start = 1'b1;
            end else if (j == 5) begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first < 0) begin
                    first = j; dig = digitos;
                end
            end else if (first < 0 && digitos !== prev) begin
                hold_ok = 1'b0;
            end
        end
        check("swb_done_count", n_done, 1);
        check("swb_latency", first, 15);
        check("swb_digitos", dig, 16'h1234);
        check("swb_hold", hold_ok, 1);
    endtask

    task automatic reset_mid();
        int n_done;
        n_done = 0;
        @(negedge clk);
        bin   = 14'd2605;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_digitos", digitos, 16'h0000);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_sobre", sobre, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_mid_no_done", n_done, 0);
        check("rst_mid_digitos_after", digitos, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check("reset_digitos", digitos, 16'h0000);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_sobre", sobre, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_conv(14'd2605, 16'h2605, 1'b0, "conv_2605");
        run_conv(14'd0,    16'h0000, 1'b0, "conv_0");
        run_conv(14'd9,    16'h0009, 1'b0, "conv_9");
        run_conv(14'd9999, 16'h9999, 1'b0, "conv_9999");
`ifdef BIN_BCD_SATURA_EN
        run_conv(14'd12345, 16'h9999, 1'b1, "conv_12345");
        run_conv(14'd16383, 16'h9999, 1'b1, "conv_16383");
`else
        run_conv(14'd12345, 16'h2345, 1'b0, "conv_12345");
        run_conv(14'd16383, 16'h6383, 1'b0, "conv_16383");
`endif
        run_conv(14'd1000, 16'h1000, 1'b0, "conv_1000");
        held_start();
        start_while_busy();
        reset_mid();
        run_conv(14'd42, 16'h0042, 1'b0, "conv_42_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
